sipo_load_ctrl: RTL and testbench

Frame scheduler that sits between the incoming byte stream (UART/host side) and the two operand SIPOs, A (weights) and B (activations), of the systolic array. It steers exactly depth_p beats into SIPO A, then depth_p beats into SIPO B, and waits until both SIPOs report full. It then pulses start to the array and waits for done before accepting the next frame. A watchdog flags a stuck SIPO or array.

---
 rtl/sipo_ctrl_pkg.sv | 16 +
 rtl/watchdog_ctr.sv | 30 +++
 rtl/sipo_load_ctrl.sv | 98 +++++++++
 tb/tb_sipo_load_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_ctrl_pkg.sv
// Shared types for the SIPO load controller.
// Holds the scheduler state encoding and frame counter width.
package sipo_ctrl_pkg;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        SYNC   = 3'd2,
        START  = 3'd3,
        BUSY   = 3'd4,
        ERR    = 3'd5
    } state_e;

    localparam int unsigned FrameCntW = 16;

endpackage

// File: rtl/watchdog_ctr.sv
// Saturating cycle counter that flags when a wait has lasted
// timeout_p cycles without being cleared.
module watchdog_ctr #(
    parameter int unsigned timeout_p = 4096
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(timeout_p);
    localparam logic [W-1:0] Last = W'(timeout_p - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && cnt_q != Last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == Last);

endmodule

// File: rtl/sipo_load_ctrl.sv
// Frame scheduler: steers beats into SIPO A then SIPO B, starts
// the array once both are full and waits for done.
module sipo_load_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned width_p   = 8,
    parameter int unsigned depth_p   = 128,
    parameter int unsigned timeout_p = 4096
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [width_p-1:0]   data_i,
    output logic                 a_valid_o,
    output logic [width_p-1:0]   a_data_o,
    output logic                 b_valid_o,
    output logic [width_p-1:0]   b_data_o,
    input  logic                 a_full_i,
    input  logic                 b_full_i,
    output logic                 start_o,
    input  logic                 done_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [FrameCntW-1:0] frame_cnt_o
);

    localparam int unsigned CntW = $clog2(depth_p);
    localparam logic [CntW-1:0] LastBeat = CntW'(depth_p - 1);

    state_e               state_q, state_d;
    logic [CntW-1:0]      beat_q;
    logic [FrameCntW-1:0] frame_q;
    logic                 xfer;
    logic                 last_beat;
    logic                 wd_clear;
    logic                 wd_en;
    logic                 wd_expired;

    assign ready_o   = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign xfer      = valid_i & ready_o;
    assign a_valid_o = xfer & (state_q == LOAD_A);
    assign b_valid_o = xfer & (state_q == LOAD_B);
    assign a_data_o  = data_i;
    assign b_data_o  = data_i;
    assign last_beat = xfer && (beat_q == LastBeat);

    // Exit conditions are tested before expiry so a late exit still wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD_A: if (last_beat) state_d = LOAD_B;
            LOAD_B: if (last_beat) state_d = SYNC;
            SYNC: begin
                if (a_full_i && b_full_i) state_d = START;
                else if (wd_expired)      state_d = ERR;
            end
            START: state_d = BUSY;
            BUSY: begin
                if (done_i)          state_d = LOAD_A;
                else if (wd_expired) state_d = ERR;
            end
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= LOAD_A;
            beat_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) beat_q <= beat_q + 1'b1;
            if (state_q == BUSY && done_i) frame_q <= frame_q + 1'b1;
        end
    end

    assign wd_clear = (state_d != state_q);
    assign wd_en    = (state_q == SYNC) || (state_q == BUSY);

    watchdog_ctr #(
        .timeout_p(timeout_p)
    ) u_wd (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    assign start_o     = (state_q == START);
    assign busy_o      = (state_q != LOAD_A);
    assign err_o       = (state_q == ERR);
    assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// Self-checking bench for sipo_load_ctrl with behavioural SIPOs
// and a frame-level expectation model.
module tb_sipo_load_ctrl;

    localparam int W = 8;
    localparam int D = 128;
    localparam int T = 4096;

    logic         clk = 1'b0;
    logic         reset_ni;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         a_valid_o;
    logic [W-1:0] a_data_o;
    logic         b_valid_o;
    logic [W-1:0] b_data_o;
    logic         a_full_i;
    logic         b_full_i;
    logic         start_o;
    logic         done_i;
    logic         busy_o;
    logic         err_o;
    logic [15:0]  frame_cnt_o;

    always #5 clk = ~clk;

    sipo_load_ctrl #(
        .width_p  (W),
        .depth_p  (D),
        .timeout_p(T)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .a_valid_o  (a_valid_o),
        .a_data_o   (a_data_o),
        .b_valid_o  (b_valid_o),
        .b_data_o   (b_data_o),
        .a_full_i   (a_full_i),
        .b_full_i   (b_full_i),
        .start_o    (start_o),
        .done_i     (done_i),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    // Behavioural SIPOs: full after depth writes, refill restarts at 0.
    int           a_wr = 0, b_wr = 0;
    int           a_pulses = 0, b_pulses = 0, starts = 0;
    logic [W-1:0] a_mem [D];
    logic [W-1:0] b_mem [D];
    logic         sipo_clr = 1'b0;
    logic         a_force = 1'b0;
    logic         b_block = 1'b0;

    assign a_full_i = (a_wr == D) || a_force;
    assign b_full_i = (b_wr == D) && !b_block;

    always @(posedge clk) begin
        if (sipo_clr) begin
            a_wr <= 0;
            b_wr <= 0;
        end else begin
            if (a_valid_o) begin
                a_mem[(a_wr == D) ? 0 : a_wr] <= a_data_o;
                a_wr <= ((a_wr == D) ? 0 : a_wr) + 1;
            end
            if (b_valid_o) begin
                b_mem[(b_wr == D) ? 0 : b_wr] <= b_data_o;
                b_wr <= ((b_wr == D) ? 0 : b_wr) + 1;
            end
        end
        if (a_valid_o) a_pulses <= a_pulses + 1;
        if (b_valid_o) b_pulses <= b_pulses + 1;
        if (start_o)   starts   <= starts + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         valid;
        logic [W-1:0] data;
        logic         exp_ready;
        logic         exp_av;
        logic         exp_bv;
    } vec_t;

    vec_t vecs [8];

    // Up to four vectors fit before the next rising edge.
    task automatic apply_vecs(input int lo, input int hi);
        @(negedge clk);
        for (int i = lo; i <= hi; i++) begin
            valid_i = vecs[i].valid;
            data_i  = vecs[i].data;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_avalid", i), 32'(a_valid_o), 32'(vecs[i].exp_av));
            check($sformatf("vec%0d_bvalid", i), 32'(b_valid_o), 32'(vecs[i].exp_bv));
            check($sformatf("vec%0d_adata", i), 32'(a_data_o), 32'(vecs[i].data));
            check($sformatf("vec%0d_bdata", i), 32'(b_data_o), 32'(vecs[i].data));
        end
        valid_i = 1'b0;
    endtask

    // Beat k of a frame goes to A for k<D, else to B.
    task automatic load_frame(input int gap, input bit stale, input int nbeats,
                              input logic [W-1:0] mask, output int bad);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        bad = 0;
        while (k < nbeats && cyc < 20 * nbeats + 100) begin
            @(negedge clk);
            valid_i = (int'($urandom_range(99)) >= gap);
            data_i  = W'(k) ^ mask;
            a_force = stale && (k < D);
            done_i  = 1'b0;
            #1;
            if (ready_o !== 1'b1) bad++;
            if (a_valid_o !== (valid_i && k < D)) bad++;
            if (b_valid_o !== (valid_i && k >= D)) bad++;
            if (a_data_o !== data_i || b_data_o !== data_i) bad++;
            if (start_o !== 1'b0 || err_o !== 1'b0) bad++;
            if (busy_o !== (k >= D)) bad++;
            if (valid_i) k++;
            cyc++;
        end
        if (k < nbeats) bad++;
    endtask

    task automatic finish_frame(input bit done_in_start, input int done_delay,
                                input int exp_cnt, input int s0);
        int c;
        int bad;
        c = 0;
        bad = 0;
        do begin
            @(negedge clk);
            valid_i = 1'($urandom_range(1));
            done_i  = done_in_start;
            a_force = 1'b0;
            #1;
            c++;
            if (ready_o !== 1'b0 || a_valid_o !== 1'b0 || b_valid_o !== 1'b0) bad++;
        end while (start_o !== 1'b1 && c < 20);
        check("start_latency", 32'(c), 32'd2);
        for (int d = 0; d <= done_delay; d++) begin
            @(negedge clk);
            done_i  = (d == done_delay);
            valid_i = 1'($urandom_range(1));
            #1;
            if (ready_o !== 1'b0 || busy_o !== 1'b1) bad++;
            if (err_o !== 1'b0 || start_o !== 1'b0) bad++;
        end
        @(negedge clk);
        done_i  = 1'b0;
        valid_i = 1'b0;
        #1;
        check("wait_phase", 32'(bad), 32'd0);
        check("ready_after_done", 32'(ready_o), 32'd1);
        check("busy_after_done", 32'(busy_o), 32'd0);
        check("err_after_done", 32'(err_o), 32'd0);
        check("frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
        check("start_count", 32'(starts - s0), 32'd1);
    endtask

    task automatic check_contents(input string name, input logic [W-1:0] mask,
                                  input int pa, input int pb);
        int bad;
        bad = 0;
        for (int i = 0; i < D; i++) begin
            if (a_mem[i] !== (W'(i) ^ mask)) bad++;
            if (b_mem[i] !== (W'(i + D) ^ mask)) bad++;
        end
        check({name, "_a_pulses"}, 32'(a_pulses - pa), 32'(D));
        check({name, "_b_pulses"}, 32'(b_pulses - pb), 32'(D));
        check({name, "_contents"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int bad, s0, pa, pb, c;

        vecs[0] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b0};

        reset_ni = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        done_i   = 1'b0;
        #12;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;

        apply_vecs(0, 3);

        // Frame 1: continuous stream.
        s0 = starts; pa = a_pulses; pb = b_pulses;
        load_frame(0, 1'b0, 2 * D, 8'h00, bad);
        check("f1_load", 32'(bad), 32'd0);
        finish_frame(1'b0, 5, 1, s0);
        check_contents("f1", 8'h00, pa, pb);

        // Frame 2: gaps, stale A full, done in START and at expiry.
        s0 = starts; pa = a_pulses; pb = b_pulses;
        load_frame(50, 1'b1, 2 * D, 8'h00, bad);
        check("f2_load", 32'(bad), 32'd0);
        finish_frame(1'b1, T - 1, 2, s0);
        check_contents("f2", 8'h00, pa, pb);

        // Reset between clock edges after 50 A beats.
        load_frame(0, 1'b0, 50, 8'h00, bad);
        check("partial_load", 32'(bad), 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        check("mid_rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        check("mid_rst_ready", 32'(ready_o), 32'd1);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        sipo_clr = 1'b1;
        @(negedge clk);
        sipo_clr = 1'b0;
        s0 = starts; pa = a_pulses; pb = b_pulses;
        load_frame(30, 1'b0, 2 * D, 8'hC3, bad);
        check("f3_load", 32'(bad), 32'd0);
        finish_frame(1'b0, 3, 1, s0);
        check_contents("f3", 8'hC3, pa, pb);

        // Watchdog: B never reports full.
        b_block = 1'b1;
        s0 = starts;
        load_frame(0, 1'b0, 2 * D, 8'h00, bad);
        check("f4_load", 32'(bad), 32'd0);
        c = 0;
        do begin
            @(negedge clk);
            valid_i = 1'b1;
            #1;
            c++;
        end while (err_o !== 1'b1 && c < T + 20);
        check("wd_latency", 32'(c), 32'(T + 1));
        check("err_ready", 32'(ready_o), 32'd0);
        check("err_avalid", 32'(a_valid_o), 32'd0);
        check("err_busy", 32'(busy_o), 32'd1);
        b_block = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", 32'(err_o), 32'd1);
        check("err_no_start", 32'(starts - s0), 32'd0);
        apply_vecs(4, 7);
        @(negedge clk);
        #2;
        reset_ni = 1'b0;
        #1;
        check("err_async_clear", 32'(err_o), 32'd0);
        check("err_rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        reset_ni = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
